// File: rtl/uart_echo_core.sv
// UART echo engine: 8N1 receiver -> byte FIFO (first-word fall-through) -> 8N1 transmitter,
// with sticky framing/overrun flags and a live FIFO occupancy count.
module uart_echo_core #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          io_systemClk,
    input  logic                          io_asyncResetn,
    input  logic                          uart_rxd,
    output logic                          uart_txd,
    input  logic                          err_clr,
    output logic                          frame_err,
    output logic                          overrun_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // ---------------- RX synchronizer ----------------
    logic rx_meta, rxs;

    always_ff @(posedge io_systemClk or negedge io_asyncResetn) begin
        if (!io_asyncResetn) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= uart_rxd;
            rxs     <= rx_meta;
        end
    end

    // ---------------- FIFO ----------------
    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wptr, rptr;
    logic        push, pop, full, empty;
    logic [7:0]  rd_data;
    logic [7:0]  rx_shift;

    // Extra wrap bit distinguishes full from empty when the index bits match.
    assign full       = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty      = (wptr == rptr);
    assign rd_data    = mem[rptr[AW-1:0]];
    assign fifo_level = wptr - rptr;

    always_ff @(posedge io_systemClk) begin
        if (push) mem[wptr[AW-1:0]] <= rx_shift;
    end

    always_ff @(posedge io_systemClk or negedge io_asyncResetn) begin
        if (!io_asyncResetn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    // ---------------- RX FSM ----------------
    state_t      rx_state, rx_state_d;
    logic [15:0] rx_cnt, rx_cnt_d;
    logic [2:0]  rx_bits, rx_bits_d;
    logic [7:0]  rx_shift_d;
    logic        rx_brk, rx_brk_d;
    logic        frame_set, overrun_set;

    always_ff @(posedge io_systemClk or negedge io_asyncResetn) begin
        if (!io_asyncResetn) begin
            rx_state <= IDLE;
            rx_cnt   <= '0;
            rx_bits  <= '0;
            rx_shift <= '0;
            rx_brk   <= 1'b0;
        end else begin
            rx_state <= rx_state_d;
            rx_cnt   <= rx_cnt_d;
            rx_bits  <= rx_bits_d;
            rx_shift <= rx_shift_d;
            rx_brk   <= rx_brk_d;
        end
    end

    always_comb begin
        rx_state_d  = rx_state;
        rx_cnt_d    = rx_cnt;
        rx_bits_d   = rx_bits;
        rx_shift_d  = rx_shift;
        rx_brk_d    = rx_brk;
        push        = 1'b0;
        frame_set   = 1'b0;
        overrun_set = 1'b0;
        case (rx_state)
            IDLE: begin
                if (!rxs) begin
                    rx_cnt_d   = HALF_M1;
                    rx_state_d = START;
                end
            end
            START: begin
                if (rx_cnt != 16'd0) begin
                    rx_cnt_d = rx_cnt - 16'd1;
                end else if (rxs) begin
                    rx_state_d = IDLE;
                end else begin
                    rx_cnt_d   = FULL_M1;
                    rx_bits_d  = 3'd0;
                    rx_state_d = DATA;
                end
            end
            DATA: begin
                if (rx_cnt != 16'd0) begin
                    rx_cnt_d = rx_cnt - 16'd1;
                end else begin
                    rx_shift_d = {rxs, rx_shift[7:1]};
                    rx_cnt_d   = FULL_M1;
                    if (rx_bits == 3'd7) rx_state_d = STOP;
                    else                 rx_bits_d  = rx_bits + 3'd1;
                end
            end
            STOP: begin
                if (rx_cnt != 16'd0) begin
                    rx_cnt_d = rx_cnt - 16'd1;
                end else if (rx_brk) begin
                    // Hold here through a break so it raises frame_err only once.
                    if (rxs) begin
                        rx_brk_d   = 1'b0;
                        rx_state_d = IDLE;
                    end
                end else if (rxs) begin
                    rx_state_d = IDLE;
                    if (full) overrun_set = 1'b1;
                    else      push        = 1'b1;
                end else begin
                    frame_set = 1'b1;
                    rx_brk_d  = 1'b1;
                end
            end
            default: rx_state_d = IDLE;
        endcase
    end

    // ---------------- TX FSM ----------------
    state_t      tx_state, tx_state_d;
    logic [15:0] tx_cnt, tx_cnt_d;
    logic [2:0]  tx_bits, tx_bits_d;
    logic [7:0]  tx_shift, tx_shift_d;
    logic        txd_d;

    always_ff @(posedge io_systemClk or negedge io_asyncResetn) begin
        if (!io_asyncResetn) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_bits  <= '0;
            tx_shift <= '0;
            uart_txd <= 1'b1;
        end else begin
            tx_state <= tx_state_d;
            tx_cnt   <= tx_cnt_d;
            tx_bits  <= tx_bits_d;
            tx_shift <= tx_shift_d;
            uart_txd <= txd_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state;
        tx_cnt_d   = tx_cnt;
        tx_bits_d  = tx_bits;
        tx_shift_d = tx_shift;
        txd_d      = uart_txd;
        pop        = 1'b0;
        case (tx_state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    tx_shift_d = rd_data;
                    txd_d      = 1'b0;
                    tx_cnt_d   = FULL_M1;
                    tx_state_d = START;
                end
            end
            START: begin
                if (tx_cnt != 16'd0) begin
                    tx_cnt_d = tx_cnt - 16'd1;
                end else begin
                    txd_d      = tx_shift[0];
                    tx_shift_d = {1'b1, tx_shift[7:1]};
                    tx_bits_d  = 3'd0;
                    tx_cnt_d   = FULL_M1;
                    tx_state_d = DATA;
                end
            end
            DATA: begin
                if (tx_cnt != 16'd0) begin
                    tx_cnt_d = tx_cnt - 16'd1;
                end else begin
                    tx_cnt_d = FULL_M1;
                    if (tx_bits == 3'd7) begin
                        txd_d      = 1'b1;
                        tx_state_d = STOP;
                    end else begin
                        txd_d      = tx_shift[0];
                        tx_shift_d = {1'b1, tx_shift[7:1]};
                        tx_bits_d  = tx_bits + 3'd1;
                    end
                end
            end
            STOP: begin
                if (tx_cnt != 16'd0) tx_cnt_d   = tx_cnt - 16'd1;
                else                 tx_state_d = IDLE;
            end
            default: tx_state_d = IDLE;
        endcase
    end

    // ---------------- Sticky error flags ----------------
    // A new event in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge io_systemClk or negedge io_asyncResetn) begin
        if (!io_asyncResetn) begin
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            frame_err   <= frame_set   | (frame_err   & ~err_clr);
            overrun_err <= overrun_set | (overrun_err & ~err_clr);
        end
    end

endmodule

// File: tb/tb_uart_echo_core.sv
// Bench for uart_echo_core: drives 8N1 frames on uart_rxd and decodes uart_txd against
// a queue of expected echo bytes.
`timescale 1ns/1ps
module tb_uart_echo_core;
    localparam int CPB   = 8;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd = 1'b1;
    logic       err_clr = 1'b0;
    logic       txd, frame_err, overrun_err;
    logic [2:0] fifo_level;

    uart_echo_core #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .io_systemClk   (clk),
        .io_asyncResetn (rst_n),
        .uart_rxd       (rxd),
        .uart_txd       (txd),
        .err_clr        (err_clr),
        .frame_err      (frame_err),
        .overrun_err    (overrun_err),
        .fifo_level     (fifo_level)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    logic       mon_busy = 1'b0;
    logic       lvl_clr  = 1'b0;
    logic [2:0] max_level = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one frame starting on a negedge. With abort_on_ovr set, overrun_err is probed
    // 3 cycles into the start bit; if set, the line goes back high (a glitch, not a frame).
    task automatic send_frame(input logic [7:0] data, input int stop_len, input logic stop_low,
                              input logic abort_on_ovr, output logic aborted);
        aborted = 1'b0;
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        if (abort_on_ovr && overrun_err) begin
            rxd = 1'b1;
            aborted = 1'b1;
        end else begin
            repeat (CPB - 3) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                rxd = data[i];
                repeat (CPB) @(negedge clk);
            end
            rxd = stop_low ? 1'b0 : 1'b1;
            repeat (stop_len) @(negedge clk);
            rxd = 1'b1;
        end
    endtask

    task automatic wait_drain(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !mon_busy) break;
        end
        check_eq(tag, {31'd0, (exp_q.size() == 0 && !mon_busy)}, 1);
    endtask

    // Peak fifo_level tracker
    initial begin
        forever begin
            @(negedge clk);
            if (lvl_clr)                      max_level = '0;
            else if (fifo_level > max_level)  max_level = fifo_level;
        end
    end

    // TX monitor: every cycle of the 10-bit frame must match, bytes compared in order.
    initial begin
        logic [7:0] exp_b, got_b;
        logic [9:0] frame;
        int         shape_err;
        logic       aborted;
        forever begin
            @(negedge clk);
            if (rst_n && txd == 1'b0) begin
                mon_busy = 1'b1;
                check_eq("tx_expected", {31'd0, exp_q.size() != 0}, 1);
                exp_b = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
                frame = {1'b1, exp_b, 1'b0};
                shape_err = 0;
                got_b = '0;
                aborted = 1'b0;
                for (int k = 0; k < 10 * CPB; k++) begin
                    if (k != 0) @(negedge clk);
                    if (!rst_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (txd !== frame[k / CPB]) shape_err++;
                    if ((k % CPB) == CPB / 2 && k / CPB >= 1 && k / CPB <= 8)
                        got_b[k / CPB - 1] = txd;
                end
                if (!aborted) begin
                    check_eq("tx_byte", got_b, exp_b);
                    check_eq("tx_frame_shape", shape_err, 0);
                end
                mon_busy = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ab, ovr_seen;
        logic [7:0] b;
        int         lows, lvls;

        // ---- reset ----
        repeat (3) @(negedge clk);
        check_eq("rst_txd", txd, 1);
        check_eq("rst_frame_err", frame_err, 0);
        check_eq("rst_overrun_err", overrun_err, 0);
        check_eq("rst_fifo_level", fifo_level, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // ---- single byte 0xA5 ----
        fork
            begin
                exp_q.push_back(8'hA5);
                send_frame(8'hA5, CPB, 1'b0, 1'b0, ab);
            end
            begin
                for (int i = 0; i < 200; i++) begin
                    @(negedge clk);
                    if (fifo_level != 0) break;
                end
                check_eq("a5_level_one", fifo_level, 1);
                @(negedge clk);
                check_eq("a5_level_zero", fifo_level, 0);
            end
        join
        wait_drain("a5_drain", 200);
        check_eq("a5_frame_err", frame_err, 0);
        check_eq("a5_overrun_err", overrun_err, 0);

        // ---- 3-cycle glitch ----
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        lows = 0;
        lvls = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (txd == 1'b0)     lows++;
            if (fifo_level != 0) lvls++;
        end
        check_eq("glitch_txd_low", lows, 0);
        check_eq("glitch_level", lvls, 0);
        check_eq("glitch_frame_err", frame_err, 0);

        // ---- framing error on 0x3C, clear, then 0x11 ----
        lvl_clr = 1'b1;
        @(negedge clk);
        lvl_clr = 1'b0;
        send_frame(8'h3C, CPB, 1'b1, 1'b0, ab);
        repeat (10) @(negedge clk);
        check_eq("ferr_set", frame_err, 1);
        check_eq("ferr_no_push", max_level, 0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check_eq("ferr_cleared", frame_err, 0);
        exp_q.push_back(8'h11);
        send_frame(8'h11, CPB, 1'b0, 1'b0, ab);
        wait_drain("ferr_11_drain", 200);
        check_eq("ferr_11_frame_err", frame_err, 0);

        // ---- 32 random bytes back-to-back at nominal rate ----
        lvl_clr = 1'b1;
        @(negedge clk);
        lvl_clr = 1'b0;
        for (int n = 0; n < 32; n++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send_frame(b, CPB, 1'b0, 1'b0, ab);
        end
        wait_drain("stream_drain", 600);
        check_eq("stream_frame_err", frame_err, 0);
        check_eq("stream_overrun_err", overrun_err, 0);
        check_eq("stream_level_le2", {31'd0, max_level <= 3'd2}, 1);

        // ---- overrun: short stop bits outpace TX ----
        lvl_clr = 1'b1;
        @(negedge clk);
        lvl_clr = 1'b0;
        ovr_seen = 1'b0;
        for (int n = 0; n < 250 && !ovr_seen; n++) begin
            b = 8'($urandom_range(0, 255));
            send_frame(b, 6, 1'b0, 1'b1, ab);
            if (ab) begin
                // The previous frame was the one dropped; it never reached the FIFO.
                ovr_seen = 1'b1;
                void'(exp_q.pop_back());
            end else begin
                exp_q.push_back(b);
            end
        end
        check_eq("ovr_seen", ovr_seen, 1);
        check_eq("ovr_flag", overrun_err, 1);
        wait_drain("ovr_drain", 1200);
        check_eq("ovr_max_level", max_level, DEPTH);
        check_eq("ovr_frame_err", frame_err, 0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check_eq("ovr_cleared", overrun_err, 0);

        // ---- reset in the middle of TX data bit 4, then 0x5A ----
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, CPB, 1'b0, 1'b0, ab);
        for (int i = 0; i < 100; i++) begin
            if (txd == 1'b0) break;
            @(negedge clk);
        end
        check_eq("rst_tx_started", txd, 0);
        repeat (5 * CPB + CPB / 2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_txd", txd, 1);
        check_eq("midrst_level", fifo_level, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("midrst_monitor_idle", mon_busy, 0);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, CPB, 1'b0, 1'b0, ab);
        wait_drain("midrst_5a_drain", 200);
        check_eq("midrst_frame_err", frame_err, 0);
        check_eq("midrst_overrun_err", overrun_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
